// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file.
// Purpose: holds the default geometry of the register file and the data and
// address types that the ALU and write-back stages use when they talk to it.
// Ports: none (package only).
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] rf_data_t;
  typedef logic [ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file.
// Purpose: compares the read address against the same-cycle write to bypass
// fresh data, masks register 0 when it is hardwired, and registers the read
// data, a valid strobe and the scoreboard hazard flag.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   rdEn_i        read enable for this port
//   rdAddr_i      read address
//   wrEff_i       a write is really happening this edge (already not dropped)
//   wrAddr_i      write address
//   wrData_i      write data
//   regData_i     stored value of the addressed register (pre-edge)
//   pending_i     pending bit of the addressed register (pre-edge)
//   data_o        registered read data, held when no read
//   valid_o       high for the cycle after a read
//   hazard_o      the captured read targeted a pending register
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W      = rf_pkg::DATA_W,
  parameter int ADDR_W      = rf_pkg::ADDR_W,
  parameter int ZERO_REG_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  input  logic              wrEff_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [DATA_W-1:0] regData_i,
  input  logic              pending_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              hazard_o
);

  localparam bit zeroEn = (ZERO_REG_EN != 0);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              hazard_q, hazard_d;
  logic              bypass;
  logic              isZeroReg;

  // A write landing on the same edge as the read is forwarded straight to
  // the output, so the reader never sees the stale stored value. A bypassed
  // read is never a hazard because the producer has just delivered.
  assign bypass    = wrEff_i && (wrAddr_i == rdAddr_i);
  assign isZeroReg = zeroEn && (rdAddr_i == '0);

  // Next-state selection for the output registers. Without a read, data and
  // hazard keep their last captured values and only valid drops.
  always_comb begin
    data_d   = data_q;
    hazard_d = hazard_q;
    valid_d  = 1'b0;
    if (rdEn_i) begin
      valid_d = 1'b1;
      if (isZeroReg) begin
        data_d   = '0;
        hazard_d = 1'b0;
      end else if (bypass) begin
        data_d   = wrData_i;
        hazard_d = 1'b0;
      end else begin
        data_d   = regData_i;
        hazard_d = pending_i;
      end
    end
  end

  // Output registers, cleared asynchronously and held clear during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      hazard_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      hazard_q <= hazard_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign hazard_o = hazard_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 16 x 16-bit register file with two registered read ports and one write port.
// Purpose: storage between write-back (W side) and the ALU operands (P/Q side),
// with a per-register pending bit that tracks results still outstanding.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   W_wr, W_addr, W_data       write port
//   Rs_set, Rs_addr            reserve: mark a register as awaiting a result
//   Rp_rd, Rp_addr             read request, port P
//   Rp_data, Rp_valid, Rp_hazard   registered read result, port P
//   Rq_rd, Rq_addr             read request, port Q
//   Rq_data, Rq_valid, Rq_hazard   registered read result, port Q
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W      = rf_pkg::DATA_W,
  parameter int ADDR_W      = rf_pkg::ADDR_W,
  parameter int ZERO_REG_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_wr,
  input  logic [ADDR_W-1:0] W_addr,
  input  logic [DATA_W-1:0] W_data,
  input  logic              Rs_set,
  input  logic [ADDR_W-1:0] Rs_addr,
  input  logic              Rp_rd,
  input  logic [ADDR_W-1:0] Rp_addr,
  output logic [DATA_W-1:0] Rp_data,
  output logic              Rp_valid,
  output logic              Rp_hazard,
  input  logic              Rq_rd,
  input  logic [ADDR_W-1:0] Rq_addr,
  output logic [DATA_W-1:0] Rq_data,
  output logic              Rq_valid,
  output logic              Rq_hazard
);

  localparam int numRegs = 2 ** ADDR_W;
  localparam bit zeroEn  = (ZERO_REG_EN != 0);

  logic [DATA_W-1:0]  regs_q [numRegs];
  logic [DATA_W-1:0]  regs_d [numRegs];
  logic [numRegs-1:0] pending_q, pending_d;
  logic               wrEff;
  logic               rsEff;

  // Writes and reserves aimed at a hardwired register 0 are simply dropped,
  // which keeps its storage at zero and its pending bit clear forever.
  assign wrEff = W_wr   && !(zeroEn && (W_addr  == '0));
  assign rsEff = Rs_set && !(zeroEn && (Rs_addr == '0));

  // Next state of the array and the scoreboard. A write clears the pending
  // bit of its target, but a reserve on the same edge is applied afterwards
  // so it wins: it represents a newer producer that is still outstanding.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wrEff) begin
      regs_d[W_addr]    = W_data;
      pending_d[W_addr] = 1'b0;
    end
    if (rsEff) begin
      pending_d[Rs_addr] = 1'b1;
    end
  end

  // Storage and scoreboard registers, all cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < numRegs; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Both read ports look at pre-edge storage and pending state, so a reserve
  // issued on the same edge as a read does not flag that read.
  rf_read_port #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) portP (
    .clk       (clk),
    .rst       (rst),
    .rdEn_i    (Rp_rd),
    .rdAddr_i  (Rp_addr),
    .wrEff_i   (wrEff),
    .wrAddr_i  (W_addr),
    .wrData_i  (W_data),
    .regData_i (regs_q[Rp_addr]),
    .pending_i (pending_q[Rp_addr]),
    .data_o    (Rp_data),
    .valid_o   (Rp_valid),
    .hazard_o  (Rp_hazard)
  );

  rf_read_port #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) portQ (
    .clk       (clk),
    .rst       (rst),
    .rdEn_i    (Rq_rd),
    .rdAddr_i  (Rq_addr),
    .wrEff_i   (wrEff),
    .wrAddr_i  (W_addr),
    .wrData_i  (W_data),
    .regData_i (regs_q[Rq_addr]),
    .pending_i (pending_q[Rq_addr]),
    .data_o    (Rq_data),
    .valid_o   (Rq_valid),
    .hazard_o  (Rq_hazard)
  );

endmodule
